mux_wb_sel_reg: RTL and testbench

//   Parametrised, registered write-back source selector for the register-file data path.

---
 rtl/mux_wb_sel_reg_if.sv | 34 +++
 rtl/mux_wb_sel_reg.sv | 116 +++++++++++
 tb/tb_mux_wb_sel_reg.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_wb_sel_reg_if.sv
// Bundle of request, source and result signals for the write-back source selector.
// Latency: none, wires only.
// Backpressure: carries hold (stall) from the consumer side; no flow control of its own.
interface mux_wb_sel_reg_if #(
    parameter int DATA_W = 32,
    parameter int N_SRC  = 8,
    parameter int SEL_W  = 4
);
    // request side
    logic                    req;
    logic                    hold;
    logic [SEL_W-1:0]        selector;
    // source buses and their per-source ready flags
    logic [N_SRC*DATA_W-1:0] data_in;
    logic [N_SRC-1:0]        src_ready;
    // registered results and status pulses
    logic [DATA_W-1:0]       result;
    logic                    valid;
    logic                    busy;
    logic                    timeout_err;
    logic                    sel_err;

    // datapath / controller side that issues requests and consumes results
    modport master (
        output req, hold, selector, data_in, src_ready,
        input  result, valid, busy, timeout_err, sel_err
    );

    // the selector block itself
    modport slave (
        input  req, hold, selector, data_in, src_ready,
        output result, valid, busy, timeout_err, sel_err
    );
endinterface

// File: rtl/mux_wb_sel_reg.sv
// Registered write-back selector: captures one of N_SRC buses, or CONST_VAL, into result.
// Latency: 1 cycle if the chosen source is ready, else waits up to TIMEOUT cycles in WAIT.
// Backpressure: hold freezes state, counter, sel_q and result and squashes pulses; req ignored while busy.
module mux_wb_sel_reg #(
    parameter int                DATA_W    = 32,
    parameter int                N_SRC     = 8,
    parameter int                SEL_W     = 4,
    parameter logic [DATA_W-1:0] CONST_VAL = DATA_W'(227),
    parameter int                TIMEOUT   = 32
) (
    input logic             clk,
    input logic             reset,
    mux_wb_sel_reg_if.slave bus
);
    // Low selector bits index a source; the MSB overrides with the constant.
    localparam int IDX_W = SEL_W - 1;
    // One spare bit so the counter can never wrap even at TIMEOUT = 2**k.
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [SEL_W-1:0] N_SRC_V  = SEL_W'(N_SRC);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   sel_q;

    logic               sel_const;
    logic [IDX_W-1:0]   sel_idx;
    logic               idx_bad;
    logic [IDX_W-1:0]   mux_idx;
    logic [DATA_W-1:0]  mux_dat;
    logic               mux_rdy;

    assign sel_const = bus.selector[SEL_W-1];
    assign sel_idx   = bus.selector[IDX_W-1:0];
    // Index field can address more slots than exist; those requests are rejected.
    assign idx_bad   = {1'b0, sel_idx} >= N_SRC_V;
    // In WAIT the latched index is authoritative; the live selector may already have moved on.
    assign mux_idx   = (state == ST_WAIT) ? sel_q : sel_idx;

    // Source mux: pick data and ready flag of the addressed source; out-of-range reads as not ready.
    always_comb begin
        mux_dat = '0;
        mux_rdy = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (mux_idx == IDX_W'(k)) begin
                mux_dat = bus.data_in[k*DATA_W +: DATA_W];
                mux_rdy = bus.src_ready[k];
            end
        end
    end

    // Capture FSM with registered result and status pulses; hold stalls everything but busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            sel_q           <= '0;
            bus.result      <= '0;
            bus.valid       <= 1'b0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.sel_err     <= 1'b0;
        end else begin
            // Pulses last one cycle unless re-asserted below; hold leaves them at 0.
            bus.valid       <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.sel_err     <= 1'b0;
            if (!bus.hold) begin
                case (state)
                    ST_IDLE: begin
                        if (bus.req) begin
                            sel_q <= sel_idx;
                            if (sel_const) begin
                                bus.result <= CONST_VAL;
                                bus.valid  <= 1'b1;
                            end else if (idx_bad) begin
                                bus.sel_err <= 1'b1;
                            end else if (mux_rdy) begin
                                bus.result <= mux_dat;
                                bus.valid  <= 1'b1;
                            end else begin
                                state    <= ST_WAIT;
                                cnt      <= '0;
                                bus.busy <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT: begin
                        // Ready is tested before the timeout so a last-cycle arrival still lands.
                        if (mux_rdy) begin
                            bus.result <= mux_dat;
                            bus.valid  <= 1'b1;
                            bus.busy   <= 1'b0;
                            state      <= ST_IDLE;
                        end else if (cnt == CNT_LAST) begin
                            bus.timeout_err <= 1'b1;
                            bus.busy        <= 1'b0;
                            state           <= ST_IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mux_wb_sel_reg.sv
// Self-checking bench for mux_wb_sel_reg: directed spec scenarios plus randomized transactions.
// Expectations come from a per-transaction plan (ready delay, hold window) rather than a state model.
// Inputs driven on the falling edge, outputs sampled 1 ns after the rising edge.
module tb_mux_wb_sel_reg;
    localparam int          DATA_W    = 32;
    localparam int          N_SRC     = 6;
    localparam int          SEL_W     = 4;
    localparam int          TIMEOUT   = 8;
    localparam logic [31:0] CONST_VAL = 32'd227;
    localparam int          NEVER     = TIMEOUT + 100;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_result;

    mux_wb_sel_reg_if #(.DATA_W(DATA_W), .N_SRC(N_SRC), .SEL_W(SEL_W)) bus ();

    mux_wb_sel_reg #(
        .DATA_W(DATA_W), .N_SRC(N_SRC), .SEL_W(SEL_W),
        .CONST_VAL(CONST_VAL), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Fill every source with random data and random ready flags.
    task automatic scramble();
        for (int k = 0; k < N_SRC; k++) begin
            bus.data_in[k*DATA_W +: DATA_W] = $urandom;
            bus.src_ready[k]                = 1'($urandom);
        end
    endtask

    // One request. Target source becomes ready at the d-th WAIT cycle (d=0: already ready).
    // nh hold cycles are inserted after WAIT cycle h. Outcome edge = 1 + min(d,TIMEOUT) + holds.
    task automatic run_txn(input string tag, input logic [3:0] sel, input int d,
                           input int h, input int nh, input logic [31:0] dv);
        logic        is_const, bad, waits, ok, fin, is_hold, rdy;
        logic [31:0] newv;
        int          idx, w, nh_eff, total, wc, hl;
        is_const = sel[3];
        idx      = int'(sel[2:0]);
        bad      = !is_const && (idx >= N_SRC);
        waits    = !is_const && !bad && (d > 0);
        w        = waits ? ((d < TIMEOUT) ? d : TIMEOUT) : 0;
        ok       = is_const || (!bad && d <= TIMEOUT);
        newv     = is_const ? CONST_VAL : dv;
        nh_eff   = (waits && h < w) ? nh : 0;
        total    = 1 + w + nh_eff;
        wc       = 0;
        hl       = nh_eff;
        for (int e = 1; e <= total; e++) begin
            @(negedge clk);
            scramble();
            is_hold = 1'b0;
            if (e == 1) begin
                bus.req      = 1'b1;
                bus.hold     = 1'b0;
                bus.selector = sel;
                rdy          = (d == 0);
            end else begin
                bus.req      = 1'($urandom);
                bus.selector = 4'($urandom);
                if (wc == h && hl > 0) begin
                    is_hold  = 1'b1;
                    bus.hold = 1'b1;
                    hl--;
                    rdy      = 1'($urandom);
                end else begin
                    bus.hold = 1'b0;
                    wc++;
                    rdy      = (wc >= d);
                end
            end
            if (!is_const && !bad) begin
                bus.data_in[idx*DATA_W +: DATA_W] = dv;
                bus.src_ready[idx]                = rdy;
            end
            @(posedge clk);
            #1;
            fin = (e == total);
            if (fin && ok) exp_result = newv;
            checks++;
            if (bus.valid !== (fin && ok)) begin
                errors++;
                $display("FAIL %s valid edge=%0d got=%b exp=%b", tag, e, bus.valid, fin && ok);
            end
            checks++;
            if (bus.timeout_err !== (fin && !ok && !bad)) begin
                errors++;
                $display("FAIL %s timeout_err edge=%0d got=%b exp=%b", tag, e, bus.timeout_err, fin && !ok && !bad);
            end
            checks++;
            if (bus.sel_err !== (e == 1 && bad)) begin
                errors++;
                $display("FAIL %s sel_err edge=%0d got=%b exp=%b", tag, e, bus.sel_err, e == 1 && bad);
            end
            checks++;
            if (bus.busy !== (waits && !fin)) begin
                errors++;
                $display("FAIL %s busy edge=%0d hold=%b got=%b exp=%b", tag, e, is_hold, bus.busy, waits && !fin);
            end
            checks++;
            if (bus.result !== exp_result) begin
                errors++;
                $display("FAIL %s result edge=%0d got=%h exp=%h", tag, e, bus.result, exp_result);
            end
        end
        bus.hold = 1'b0;
        bus.req  = 1'b0;
    endtask

    // Async reset asserted mid-cycle clears outputs without waiting for a clock edge.
    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.result !== 32'd0 || bus.valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.timeout_err !== 1'b0 || bus.sel_err !== 1'b0) begin
            errors++;
            $display("FAIL reset result=%h valid=%b busy=%b terr=%b serr=%b exp 0/0/0/0/0",
                     bus.result, bus.valid, bus.busy, bus.timeout_err, bus.sel_err);
        end
        exp_result = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_const();
        run_txn("const", 4'b1000, 0, 0, 0, 32'h0);
        run_txn("const_msb_idx7", 4'b1111, NEVER, 0, 0, 32'h0);
    endtask

    task automatic test_immediate();
        run_txn("immediate", 4'd3, 0, 0, 0, 32'hDEADBEEF);
    endtask

    task automatic test_wait();
        run_txn("wait4", 4'd5, 4, 0, 0, 32'h12345678);
    endtask

    task automatic test_timeout();
        run_txn("timeout", 4'd1, NEVER, 0, 0, 32'hAAAA5555);
        run_txn("race", 4'd4, TIMEOUT, 0, 0, 32'hC0FFEE01);
    endtask

    task automatic test_hold();
        run_txn("hold_timeout", 4'd2, NEVER, 2, 3, 32'h0BADF00D);
        run_txn("hold_ready", 4'd0, 5, 1, 2, 32'h76543210);
    endtask

    task automatic test_sel_err();
        run_txn("sel_err7", 4'd7, 0, 0, 0, 32'h11111111);
        run_txn("sel_err6", 4'd6, 0, 0, 0, 32'h22222222);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run_txn("b2b", 4'($urandom_range(0, N_SRC - 1)), 0, 0, 0, $urandom);
        run_txn("b2b_const", 4'b1010, 0, 0, 0, 32'h0);
    endtask

    task automatic test_random();
        logic [3:0] sel;
        int         d, h, nh, m, w;
        for (int i = 0; i < 60; i++) begin
            m = $urandom_range(0, 5);
            if (m == 0)      sel = {1'b1, 3'($urandom)};
            else if (m == 1) sel = 4'($urandom_range(N_SRC, 7));
            else             sel = 4'($urandom_range(0, N_SRC - 1));
            d  = $urandom_range(0, TIMEOUT + 2);
            w  = (d < TIMEOUT) ? d : TIMEOUT;
            h  = 0;
            nh = 0;
            if (d > 0 && $urandom_range(0, 1) == 1) begin
                h  = $urandom_range(0, w - 1);
                nh = $urandom_range(1, 3);
            end
            run_txn("random", sel, d, h, nh, $urandom);
        end
    endtask

    // req while hold is high in IDLE must not start anything.
    task automatic test_hold_idle();
        @(negedge clk);
        scramble();
        bus.src_ready = '1;
        bus.req       = 1'b1;
        bus.hold      = 1'b1;
        bus.selector  = 4'b1000;
        @(posedge clk);
        #1;
        checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== exp_result) begin
            errors++;
            $display("FAIL hold_idle valid=%b busy=%b result=%h exp 0/0/%h",
                     bus.valid, bus.busy, bus.result, exp_result);
        end
        bus.hold = 1'b0;
        bus.req  = 1'b0;
    endtask

    // Reset during WAIT abandons the capture: no valid even once the source turns ready.
    task automatic test_reset_mid_wait();
        run_txn("pre_reset", 4'd4, 0, 0, 0, 32'hFEEDFACE);
        @(negedge clk);
        scramble();
        bus.req          = 1'b1;
        bus.selector     = 4'd2;
        bus.src_ready[2] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_enter busy got=%b exp=1", bus.busy);
        end
        bus.req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            scramble();
            bus.src_ready[2] = 1'b0;
            @(posedge clk);
        end
        #2 reset = 1'b1;
        #1;
        exp_result = 32'd0;
        checks++;
        if (bus.busy !== 1'b0 || bus.result !== 32'd0 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wait busy=%b result=%h valid=%b exp 0/0/0",
                     bus.busy, bus.result, bus.valid);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            scramble();
            bus.src_ready[2] = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'd0) begin
                errors++;
                $display("FAIL rst_after valid=%b busy=%b result=%h exp 0/0/0",
                         bus.valid, bus.busy, bus.result);
            end
        end
    endtask

    initial begin
        bus.req      = 1'b0;
        bus.hold     = 1'b0;
        bus.selector = '0;
        bus.data_in  = '0;
        bus.src_ready = '0;
        exp_result   = 32'd0;
        test_reset();
        test_const();
        test_immediate();
        test_wait();
        test_timeout();
        test_hold();
        test_sel_err();
        test_back_to_back();
        test_random();
        test_hold_idle();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
